// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// Resolves the pipeline hazards that EX-stage bypassing cannot cover. It stalls
// F/D and bubbles E on load-use hazards, on branch/jr operands consumed in
// decode, and on HI/LO accesses while the multi-cycle mul/div unit is busy. It
// also drives the decode-stage compare forwarding selects, tracks mul/div
// occupancy, and counts stall cycles.
//
// Ports
//   clk, rst                   clock (rising edge), async active-high reset
//   Rs_D, Rt_D                 decode source register addresses
//   UseRs_D, UseRt_D           decode instruction reads Rs / Rt
//   Branch_D, Jr_D             decode beq/bne, decode jr/jalr
//   HiLoUse_D                  decode mfhi/mflo/mult/div
//   PCSrc_D                    control transfer resolved taken in D
//   RegWrDst_E/RegWr_E/MemToReg_E   EX destination, write enable, load flag
//   RegWrDst_M/RegWr_M/MemToReg_M   MEM destination, write enable, load flag
//   MulDivStart_E, IsDiv_E     mul/div enters EX, divide (1) or multiply (0)
//   CntClr                     synchronous clear of StallCnt
//   Stall_F, Stall_D, Flush_E  hold PC and IF/ID, bubble into ID/EX
//   Flush_D                    squash IF/ID on a taken control transfer
//   Forward_AD, Forward_BD     select MEM ALU result for the D-stage compare
//   MulDivBusy, MulDivDone     unit occupied, pulse on final busy cycle
//   StallCnt                   number of cycles with Stall_D=1 (wraps)
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs_D,
    input  logic [4:0]       Rt_D,
    input  logic             UseRs_D,
    input  logic             UseRt_D,
    input  logic             Branch_D,
    input  logic             Jr_D,
    input  logic             HiLoUse_D,
    input  logic             PCSrc_D,
    input  logic [4:0]       RegWrDst_E,
    input  logic             RegWr_E,
    input  logic             MemToReg_E,
    input  logic [4:0]       RegWrDst_M,
    input  logic             RegWr_M,
    input  logic             MemToReg_M,
    input  logic             MulDivStart_E,
    input  logic             IsDiv_E,
    input  logic             CntClr,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Flush_E,
    output logic             Flush_D,
    output logic             Forward_AD,
    output logic             Forward_BD,
    output logic             MulDivBusy,
    output logic             MulDivDone,
    output logic [CNT_W-1:0] StallCnt
);

    localparam int unsigned MAXC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int unsigned MDW  = (MAXC > 2) ? $clog2(MAXC) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    md_state_e        state_q, state_d;
    logic [MDW-1:0]   mdcnt_q, mdcnt_d;
    logic [CNT_W-1:0] stallcnt_q, stallcnt_d;

    logic match_e_rs, match_e_rt, match_m_rs, match_m_rt;
    logic lw_stall, br_stall, jr_stall, md_stall, stall;

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    always_comb begin
        match_e_rs = RegWr_E && (RegWrDst_E != '0) && (RegWrDst_E == Rs_D);
        match_e_rt = RegWr_E && (RegWrDst_E != '0) && (RegWrDst_E == Rt_D);
        match_m_rs = RegWr_M && (RegWrDst_M != '0) && (RegWrDst_M == Rs_D);
        match_m_rt = RegWr_M && (RegWrDst_M != '0) && (RegWrDst_M == Rt_D);

        lw_stall = MemToReg_E && ((UseRs_D && match_e_rs) || (UseRt_D && match_e_rt));

        // A D-stage compare cannot take EX results at all, nor a load still in MEM.
        br_stall = Branch_D &&
                   ((UseRs_D && (match_e_rs || (match_m_rs && MemToReg_M))) ||
                    (UseRt_D && (match_e_rt || (match_m_rt && MemToReg_M))));

        jr_stall = Jr_D && (match_e_rs || (match_m_rs && MemToReg_M));

        md_stall = HiLoUse_D && ((state_q == BUSY) || MulDivStart_E);

        // Outputs are held low for the whole reset interval, not just after it.
        stall = !rst && (lw_stall || br_stall || jr_stall || md_stall);
    end

    assign Stall_F    = stall;
    assign Stall_D    = stall;
    assign Flush_E    = stall;
    assign Flush_D    = !rst && PCSrc_D && !stall;
    assign Forward_AD = !rst && match_m_rs && !MemToReg_M;
    assign Forward_BD = !rst && match_m_rt && !MemToReg_M;

    // -------------------------------------------------------------------------
    // Mul/div occupancy FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mdcnt_q <= '0;
        end else begin
            state_q <= state_d;
            mdcnt_q <= mdcnt_d;
        end
    end

    // Counter is loaded with N-2 so BUSY lasts exactly N-1 cycles after start.
    always_comb begin
        state_d = state_q;
        mdcnt_d = mdcnt_q;
        unique case (state_q)
            IDLE: begin
                if (MulDivStart_E) begin
                    state_d = BUSY;
                    mdcnt_d = IsDiv_E ? MDW'(DIV_CYCLES - 2) : MDW'(MUL_CYCLES - 2);
                end
            end
            BUSY: begin
                if (mdcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    mdcnt_d = mdcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                mdcnt_d = '0;
            end
        endcase
    end

    always_comb begin
        MulDivBusy = (state_q == BUSY);
        MulDivDone = (state_q == BUSY) && (mdcnt_q == '0);
    end

    // -------------------------------------------------------------------------
    // Stall performance counter
    // -------------------------------------------------------------------------
    always_comb begin
        stallcnt_d = stallcnt_q;
        if (CntClr) begin
            stallcnt_d = '0;
        end else if (stall) begin
            stallcnt_d = stallcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallcnt_q <= '0;
        end else begin
            stallcnt_q <= stallcnt_d;
        end
    end

    assign StallCnt = stallcnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Directed bench for hazard_stall_unit. The main instance uses MUL_CYCLES=16 so
// a multiply is still busy at cycle 10; a second instance with CNT_W=4 shares
// all inputs and exercises the counter wrap.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

    logic       clk;
    logic       rst;
    logic [4:0] Rs_D, Rt_D;
    logic       UseRs_D, UseRt_D, Branch_D, Jr_D, HiLoUse_D, PCSrc_D;
    logic [4:0] RegWrDst_E, RegWrDst_M;
    logic       RegWr_E, MemToReg_E, RegWr_M, MemToReg_M;
    logic       MulDivStart_E, IsDiv_E, CntClr;
    logic       Stall_F, Stall_D, Flush_E, Flush_D, Forward_AD, Forward_BD;
    logic       MulDivBusy, MulDivDone;
    logic [31:0] StallCnt;
    logic       w_Stall_F, w_Stall_D, w_Flush_E, w_Flush_D, w_Forward_AD, w_Forward_BD;
    logic       w_MulDivBusy, w_MulDivDone;
    logic [3:0] w_StallCnt;

    int asserts = 0;
    int errors  = 0;

    hazard_stall_unit #(
        .MUL_CYCLES (16),
        .DIV_CYCLES (32),
        .CNT_W      (32)
    ) dut (
        .clk(clk), .rst(rst), .Rs_D(Rs_D), .Rt_D(Rt_D), .UseRs_D(UseRs_D), .UseRt_D(UseRt_D),
        .Branch_D(Branch_D), .Jr_D(Jr_D), .HiLoUse_D(HiLoUse_D), .PCSrc_D(PCSrc_D),
        .RegWrDst_E(RegWrDst_E), .RegWr_E(RegWr_E), .MemToReg_E(MemToReg_E),
        .RegWrDst_M(RegWrDst_M), .RegWr_M(RegWr_M), .MemToReg_M(MemToReg_M),
        .MulDivStart_E(MulDivStart_E), .IsDiv_E(IsDiv_E), .CntClr(CntClr),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_E(Flush_E), .Flush_D(Flush_D),
        .Forward_AD(Forward_AD), .Forward_BD(Forward_BD),
        .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone), .StallCnt(StallCnt)
    );

    hazard_stall_unit #(
        .MUL_CYCLES (4),
        .DIV_CYCLES (32),
        .CNT_W      (4)
    ) dut_w (
        .clk(clk), .rst(rst), .Rs_D(Rs_D), .Rt_D(Rt_D), .UseRs_D(UseRs_D), .UseRt_D(UseRt_D),
        .Branch_D(Branch_D), .Jr_D(Jr_D), .HiLoUse_D(HiLoUse_D), .PCSrc_D(PCSrc_D),
        .RegWrDst_E(RegWrDst_E), .RegWr_E(RegWr_E), .MemToReg_E(MemToReg_E),
        .RegWrDst_M(RegWrDst_M), .RegWr_M(RegWr_M), .MemToReg_M(MemToReg_M),
        .MulDivStart_E(MulDivStart_E), .IsDiv_E(IsDiv_E), .CntClr(CntClr),
        .Stall_F(w_Stall_F), .Stall_D(w_Stall_D), .Flush_E(w_Flush_E), .Flush_D(w_Flush_D),
        .Forward_AD(w_Forward_AD), .Forward_BD(w_Forward_BD),
        .MulDivBusy(w_MulDivBusy), .MulDivDone(w_MulDivDone), .StallCnt(w_StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A new mul/div must never enter EX while the unit is still occupied.
    always @(posedge clk) begin
        if (!rst && MulDivStart_E && MulDivBusy) begin
            errors++;
            $display("FAIL md_start_while_busy: start=%b busy=%b, required busy=0", MulDivStart_E, MulDivBusy);
        end
    end

    // Watchdog so the run always reaches a conclusion.
    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t exceeded, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic idle_inputs();
        Rs_D = 5'd0; Rt_D = 5'd0; UseRs_D = 0; UseRt_D = 0;
        Branch_D = 0; Jr_D = 0; HiLoUse_D = 0; PCSrc_D = 0;
        RegWrDst_E = 5'd0; RegWr_E = 0; MemToReg_E = 0;
        RegWrDst_M = 5'd0; RegWr_M = 0; MemToReg_M = 0;
        MulDivStart_E = 0; IsDiv_E = 0; CntClr = 0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        // Load-use hazard present while in reset: outputs must still read 0.
        RegWrDst_E = 5'd5; RegWr_E = 1; MemToReg_E = 1; Rs_D = 5'd5; UseRs_D = 1; PCSrc_D = 1;
        RegWrDst_M = 5'd6; RegWr_M = 1; Rt_D = 5'd6;
        repeat (2) step();
        asserts++;
        if ({Stall_F, Stall_D, Flush_E, Flush_D, Forward_AD, Forward_BD, MulDivBusy, MulDivDone} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 00000000",
                     {Stall_F, Stall_D, Flush_E, Flush_D, Forward_AD, Forward_BD, MulDivBusy, MulDivDone});
        end
        asserts++;
        if (StallCnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stallcnt: got %0d, required 0", StallCnt);
        end
        idle_inputs();
        #2 rst = 1'b0;
        step();
    endtask

    task automatic test_load_use();
        RegWrDst_E = 5'd5; RegWr_E = 1; MemToReg_E = 1; Rs_D = 5'd5; UseRs_D = 1;
        #1;
        asserts++;
        if ({Stall_F, Stall_D, Flush_E} !== 3'b111) begin
            errors++;
            $display("FAIL load_use_stall: got %b, required 111", {Stall_F, Stall_D, Flush_E});
        end
        // Next cycle the load has moved to M, a plain register read is no hazard.
        step();
        RegWrDst_E = 5'd0; RegWr_E = 0; MemToReg_E = 0;
        RegWrDst_M = 5'd5; RegWr_M = 1; MemToReg_M = 1;
        #1;
        asserts++;
        if ({Stall_F, Stall_D, Flush_E} !== 3'b000) begin
            errors++;
            $display("FAIL load_use_one_cycle: got %b, required 000", {Stall_F, Stall_D, Flush_E});
        end
        idle_inputs();
        RegWrDst_E = 5'd5; RegWr_E = 1; MemToReg_E = 1; Rs_D = 5'd5; UseRs_D = 0;
        #1;
        asserts++;
        if (Stall_D !== 1'b0) begin
            errors++;
            $display("FAIL load_use_unused_rs: got %b, required 0", Stall_D);
        end
        RegWrDst_E = 5'd0; Rs_D = 5'd0; UseRs_D = 1;
        #1;
        asserts++;
        if (Stall_D !== 1'b0) begin
            errors++;
            $display("FAIL load_use_r0: got %b, required 0", Stall_D);
        end
        RegWrDst_E = 5'd9; Rt_D = 5'd9; UseRt_D = 1; Rs_D = 5'd3;
        #1;
        asserts++;
        if (Stall_D !== 1'b1) begin
            errors++;
            $display("FAIL load_use_rt: got %b, required 1", Stall_D);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_branch();
        Branch_D = 1; Rs_D = 5'd2; Rt_D = 5'd7; UseRs_D = 1; UseRt_D = 1;
        RegWr_M = 1; RegWrDst_M = 5'd7; MemToReg_M = 0;
        #1;
        asserts++;
        if ({Forward_AD, Forward_BD, Stall_D} !== 3'b010) begin
            errors++;
            $display("FAIL branch_fwd_alu: got AD/BD/stall=%b, required 010", {Forward_AD, Forward_BD, Stall_D});
        end
        MemToReg_M = 1;
        #1;
        asserts++;
        if ({Forward_AD, Forward_BD, Stall_D} !== 3'b001) begin
            errors++;
            $display("FAIL branch_load_in_m: got AD/BD/stall=%b, required 001", {Forward_AD, Forward_BD, Stall_D});
        end
        // ALU result still in E cannot be forwarded to D.
        MemToReg_M = 0; RegWr_M = 0; RegWr_E = 1; RegWrDst_E = 5'd2;
        #1;
        asserts++;
        if ({Forward_AD, Stall_D} !== 2'b01) begin
            errors++;
            $display("FAIL branch_alu_in_e: got AD/stall=%b, required 01", {Forward_AD, Stall_D});
        end
        // Rs forward from M ALU result.
        RegWr_E = 0; RegWr_M = 1; RegWrDst_M = 5'd2;
        #1;
        asserts++;
        if ({Forward_AD, Forward_BD, Stall_D} !== 3'b100) begin
            errors++;
            $display("FAIL branch_fwd_rs: got AD/BD/stall=%b, required 100", {Forward_AD, Forward_BD, Stall_D});
        end
        idle_inputs();
        Jr_D = 1; Rs_D = 5'd31; RegWr_E = 1; RegWrDst_E = 5'd31;
        #1;
        asserts++;
        if (Stall_D !== 1'b1) begin
            errors++;
            $display("FAIL jr_match_e: got %b, required 1", Stall_D);
        end
        RegWr_E = 0; RegWr_M = 1; RegWrDst_M = 5'd31; MemToReg_M = 1;
        #1;
        asserts++;
        if (Stall_D !== 1'b1) begin
            errors++;
            $display("FAIL jr_load_in_m: got %b, required 1", Stall_D);
        end
        MemToReg_M = 0;
        #1;
        asserts++;
        if ({Forward_AD, Stall_D} !== 2'b10) begin
            errors++;
            $display("FAIL jr_fwd_m: got AD/stall=%b, required 10", {Forward_AD, Stall_D});
        end
        idle_inputs();
        step();
    endtask

    task automatic test_taken_branch();
        Branch_D = 1; PCSrc_D = 1; Rs_D = 5'd4; Rt_D = 5'd8; UseRs_D = 1; UseRt_D = 1;
        #1;
        asserts++;
        if ({Flush_D, Stall_D, Flush_E} !== 3'b100) begin
            errors++;
            $display("FAIL taken_flush: got FlushD/StallD/FlushE=%b, required 100", {Flush_D, Stall_D, Flush_E});
        end
        RegWr_E = 1; RegWrDst_E = 5'd8;
        #1;
        asserts++;
        if ({Flush_D, Stall_D, Flush_E} !== 3'b011) begin
            errors++;
            $display("FAIL taken_stalled: got FlushD/StallD/FlushE=%b, required 011", {Flush_D, Stall_D, Flush_E});
        end
        idle_inputs();
        step();
    endtask

    task automatic test_div_occupancy();
        logic exp_busy, exp_done, exp_stall;
        MulDivStart_E = 1; IsDiv_E = 1; HiLoUse_D = 1;
        #1;
        asserts++;
        if ({MulDivBusy, MulDivDone, Stall_D} !== 3'b001) begin
            errors++;
            $display("FAIL div_cycle0: got busy/done/stall=%b, required 001", {MulDivBusy, MulDivDone, Stall_D});
        end
        for (int c = 1; c <= 33; c++) begin
            step();
            MulDivStart_E = 0; IsDiv_E = 0;
            #1;
            exp_busy  = (c <= 31);
            exp_done  = (c == 31);
            exp_stall = (c <= 31);
            asserts++;
            if ({MulDivBusy, MulDivDone, Stall_D} !== {exp_busy, exp_done, exp_stall}) begin
                errors++;
                $display("FAIL div_cycle%0d: got busy/done/stall=%b, required %b", c,
                         {MulDivBusy, MulDivDone, Stall_D}, {exp_busy, exp_done, exp_stall});
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_busy();
        MulDivStart_E = 1; IsDiv_E = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            MulDivStart_E = 0;
        end
        #1;
        asserts++;
        if (MulDivBusy !== 1'b1) begin
            errors++;
            $display("FAIL mul_busy_cycle10: got %b, required 1", MulDivBusy);
        end
        rst = 1'b1;
        #1;
        asserts++;
        if ({MulDivBusy, MulDivDone} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_busy: got busy/done=%b, required 00", {MulDivBusy, MulDivDone});
        end
        step();
        rst = 1'b0;
        step();
        HiLoUse_D = 1;
        #1;
        asserts++;
        if ({MulDivBusy, Stall_D} !== 2'b00) begin
            errors++;
            $display("FAIL hilo_after_reset: got busy/stall=%b, required 00", {MulDivBusy, Stall_D});
        end
        idle_inputs();
        step();
    endtask

    task automatic test_counter();
        CntClr = 1;
        step();
        CntClr = 0;
        RegWrDst_E = 5'd5; RegWr_E = 1; MemToReg_E = 1; Rs_D = 5'd5; UseRs_D = 1;
        repeat (3) step();
        idle_inputs();
        asserts++;
        if (StallCnt !== 32'd3) begin
            errors++;
            $display("FAIL stallcnt_three: got %0d, required 3", StallCnt);
        end
        step();
        asserts++;
        if (StallCnt !== 32'd3) begin
            errors++;
            $display("FAIL stallcnt_hold: got %0d, required 3", StallCnt);
        end
        RegWrDst_E = 5'd5; RegWr_E = 1; MemToReg_E = 1; Rs_D = 5'd5; UseRs_D = 1; CntClr = 1;
        step();
        idle_inputs();
        asserts++;
        if (StallCnt !== 32'd0) begin
            errors++;
            $display("FAIL stallcnt_clr_priority: got %0d, required 0", StallCnt);
        end
        // Wrap on the 4-bit instance.
        HiLoUse_D = 1; MulDivStart_E = 0;
        Jr_D = 1; Rs_D = 5'd12; RegWr_E = 1; RegWrDst_E = 5'd12;
        repeat (15) step();
        asserts++;
        if (w_StallCnt !== 4'd15) begin
            errors++;
            $display("FAIL stallcnt_w15: got %0d, required 15", w_StallCnt);
        end
        step();
        idle_inputs();
        asserts++;
        if (w_StallCnt !== 4'd0) begin
            errors++;
            $display("FAIL stallcnt_wrap: got %0d, required 0", w_StallCnt);
        end
        asserts++;
        if (StallCnt !== 32'd16) begin
            errors++;
            $display("FAIL stallcnt_wide16: got %0d, required 16", StallCnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_taken_branch();
        test_div_occupancy();
        test_reset_mid_busy();
        test_counter();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Companion to the EX-stage forwarding unit. It handles the hazards that bypassing cannot cover by stalling F/D and inserting bubbles into E.
- Covered hazards: load-use hazards, branch/jr operands consumed in decode, and HI/LO reads while the multi-cycle mul/div unit is busy.
- Also drives the decode-stage branch-compare forwarding selects and a stall-cycle performance counter.
- Sits beside the pipeline registers in the datapath.

Parameters:
- MUL_CYCLES, 4, total EX cycles of a multiply (>=2).
- DIV_CYCLES, 32, total EX cycles of a divide (>=2).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- Rs_D, Rt_D  in  5 each  decode-stage source register addresses.
- UseRs_D, UseRt_D  in  1 each  decode instruction actually reads Rs / Rt.
- Branch_D  in  1  decode instruction is a beq/bne (compares in D).
- Jr_D  in  1  decode instruction is jr/jalr (reads Rs in D).
- HiLoUse_D  in  1  decode instruction is mfhi/mflo/mult/div.
- PCSrc_D  in  1  branch/jump resolved taken in D.
- RegWrDst_E, RegWr_E, MemToReg_E  in  5/1/1  EX-stage destination, write enable, load flag.
- RegWrDst_M, RegWr_M, MemToReg_M  in  5/1/1  MEM-stage destination, write enable, load flag.
- MulDivStart_E  in  1  mult/div enters EX this cycle.
- IsDiv_E  in  1  1 = divide, 0 = multiply (valid with MulDivStart_E).
- CntClr  in  1  synchronous clear of the stall counter.
- Stall_F, Stall_D  out  1 each  hold PC / IF-ID register.
- Flush_E  out  1  bubble into ID-EX register.
- Flush_D  out  1  squash IF-ID register (taken control transfer).
- Forward_AD, Forward_BD  out  1 each  select the MEM-stage ALU result for the D-stage Rs / Rt compare.
- MulDivBusy  out  1  mul/div unit occupied.
- MulDivDone  out  1  one-cycle pulse on the final busy cycle.
- StallCnt  out  CNT_W  number of cycles with Stall_D=1.

Behaviour:
- Reset (async, immediate):
  - Mul/div FSM = IDLE, down-counter = 0, StallCnt = 0.
  - All stall/flush/forward outputs, MulDivBusy and MulDivDone read 0 while rst=1.
- matchE(x) = RegWr_E & (RegWrDst_E!=0) & (RegWrDst_E==x). matchM(x) is defined the same way on the M signals.
- Terms:
  - lw_stall = MemToReg_E & ((UseRs_D & matchE(Rs_D)) | (UseRt_D & matchE(Rt_D))).
  - br_stall = Branch_D & (any used source matchE, or matchM with MemToReg_M).
  - jr_stall = Jr_D & (matchE(Rs_D) or (matchM(Rs_D) & MemToReg_M)).
  - md_stall = HiLoUse_D & (MulDivBusy | MulDivStart_E).
- Stall outputs: stall = lw_stall | br_stall | jr_stall | md_stall. Stall_F = Stall_D = Flush_E = stall, all combinational and same-cycle.
- Flush_D = PCSrc_D & ~stall. A stalled branch never flushes; it resolves on the retry cycle.
- Forward_AD = matchM(Rs_D) & ~MemToReg_M. Forward_BD is the same with Rt_D.
- Mul/div FSM (states IDLE, BUSY):
  - IDLE: when MulDivStart_E=1, go to BUSY and load the counter with (IsDiv_E ? DIV_CYCLES : MUL_CYCLES) - 2.
  - BUSY: the counter decrements each cycle. When the counter is 0, assert MulDivDone and return to IDLE next edge.
  - A MulDivStart_E in BUSY is ignored. The stall logic makes it unreachable; the bench flags it.
  - MulDivBusy = (state==BUSY). It is high exactly (N-1) cycles after the start cycle, where N = MUL_CYCLES or DIV_CYCLES.
  - Reset mid-operation returns the FSM to IDLE and drops Busy/Done the same instant.
- Stall counter:
  - Increments by 1 on each clock edge where Stall_D=1, and wraps at 2^CNT_W.
  - CntClr has priority over increment: the next value is 0.
- Priority: all stall causes OR together. Flush_E is asserted whenever stall=1, including during a taken branch.

Test Plan:
- Load-use: E = lw, RegWrDst_E=5, MemToReg_E=1, RegWr_E=1; D: Rs_D=5, UseRs_D=1 -> Stall_F=Stall_D=Flush_E=1 for exactly 1 cycle. With UseRs_D=0, or RegWrDst_E=0 -> no stall.
- Branch in D: Branch_D=1, Rt_D=7. M: RegWr_M=1, RegWrDst_M=7, MemToReg_M=0 -> Forward_BD=1, stall=0. Same with MemToReg_M=1 -> stall=1, Forward_BD=0.
- Taken branch: PCSrc_D=1, no hazard -> Flush_D=1, Stall_D=0. PCSrc_D=1 with br_stall -> Flush_D=0.
- Divide occupancy (DIV_CYCLES=32): MulDivStart_E=1, IsDiv_E=1 at cycle 0 -> MulDivBusy=1 for cycles 1..31, MulDivDone=1 at cycle 31 only. HiLoUse_D=1 at cycles 0..31 -> stall=1; at cycle 32 -> stall=0.
- Reset mid-BUSY: assert rst at cycle 10 of a multiply -> MulDivBusy=0 immediately. After release, HiLoUse_D=1 -> no stall.
- Counter: 3 stall cycles -> StallCnt=3; CntClr together with a stall -> StallCnt=0. Preload the wrap case at CNT_W=4: 15 + 1 stall -> 0.
